tz_grant_scheduler: RTL and testbench

Sequential grant scheduler built around the trailing-zero counter. Accepts a request bit-vector through a valid/ready handshake, then issues one grant per handshake, lowest set bit first, clearing each serviced bit until the vector is empty. It sits between a requester bank that posts pending-work bitmaps and a single shared consumer that can service one index per cycle.

---
 rtl/tz_pkg.sv | 13 +
 rtl/tzeros.sv | 25 ++
 rtl/tz_grant_scheduler.sv | 83 ++++++++
 tb/tb_tz_grant_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tz_pkg: shared types for the trailing-zero grant scheduler  rev 1.0   |
// +----------------------------------------------------------------------+
package tz_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } sched_state_t;

endpackage : tz_pkg
`default_nettype wire

// File: rtl/tzeros.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tzeros: trailing-zero counter, yields DATA_WIDTH for zero input  r1.0 |
// +----------------------------------------------------------------------+
module tzeros #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [$clog2(DATA_WIDTH):0]   dout
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  // Scan from the top down so the lowest set bit is the one that sticks.
  always_comb begin
    dout = CNT_W'(DATA_WIDTH);
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (din[i]) begin
        dout = CNT_W'(i);
      end
    end
  end

endmodule : tzeros
`default_nettype wire

// File: rtl/tz_grant_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tz_grant_scheduler: one grant per handshake, lowest pending bit  r1.0 |
// +----------------------------------------------------------------------+
module tz_grant_scheduler
  import tz_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  input  logic [DATA_WIDTH-1:0]           req_bits,
  output logic                            req_ready,
  output logic                            grant_valid,
  input  logic                            grant_ready,
  output logic [$clog2(DATA_WIDTH)-1:0]   grant_idx,
  output logic                            grant_last,
  input  logic                            flush,
  output logic                            busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  sched_state_t            state;
  logic [DATA_WIDTH-1:0]   pending;
  logic [DATA_WIDTH-1:0]   pending_rest;
  logic [IDX_W:0]          tz_count;
  logic                    serving;
  logic                    single_bit;

  tzeros #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tzeros (
    .din  (pending),
    .dout (tz_count)
  );

  // Clearing the lowest set bit is exactly clearing bit grant_idx.
  assign pending_rest = pending & (pending - DATA_WIDTH'(1));
  assign single_bit   = (pending_rest == '0);
  assign serving      = (state == ST_SERVE);

  assign req_ready   = !serving;
  assign busy        = serving;
  assign grant_valid = serving;
  assign grant_idx   = serving ? tz_count[IDX_W-1:0] : '0;
  assign grant_last  = serving & single_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // An all-zero vector is consumed here without ever leaving idle.
          if (req_valid && (req_bits != '0)) begin
            pending <= req_bits;
            state   <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (flush) begin
            pending <= '0;
            state   <= ST_IDLE;
          end else if (grant_ready) begin
            pending <= pending_rest;
            if (single_bit) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule : tz_grant_scheduler
`default_nettype wire

// File: tb/tb_tz_grant_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tz_grant_scheduler: directed self-checking bench            r1.0   |
// +----------------------------------------------------------------------+
module tb_tz_grant_scheduler;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_bits;
  logic       req_ready;
  logic       grant_valid;
  logic       grant_ready;
  logic [2:0] grant_idx;
  logic       grant_last;
  logic       flush;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  tz_grant_scheduler #(
    .DATA_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_bits    (req_bits),
    .req_ready   (req_ready),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_idx   (grant_idx),
    .grant_last  (grant_last),
    .flush       (flush),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd1);
    check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_grant_idx"},   32'(grant_idx),   32'd0);
    check({tag, "_grant_last"},  32'(grant_last),  32'd0);
  endtask

  task automatic check_grant(input string tag, input int idx, input logic last);
    check({tag, "_grant_valid"}, 32'(grant_valid), 32'd1);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    check({tag, "_busy"},        32'(busy),        32'd1);
    check({tag, "_grant_idx"},   32'(grant_idx),   32'(idx));
    check({tag, "_grant_last"},  32'(grant_last),  32'(last));
  endtask

  // Present a vector for one accepting cycle; afterwards the scheduler is serving.
  task automatic send(input logic [7:0] bits);
    req_valid = 1'b1;
    req_bits  = bits;
    cycle();
    req_valid = 1'b0;
    req_bits  = 8'h00;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_bits    = 8'h00;
    grant_ready = 1'b0;
    flush       = 1'b0;

    #12;
    check_idle("rst_low");
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_idle("rst_rel");

    // Sparse vector 1000_1000
    grant_ready = 1'b1;
    send(8'b1000_1000);
    check_grant("sparse_a", 3, 1'b0);
    cycle();
    check_grant("sparse_b", 7, 1'b1);
    cycle();
    check_idle("sparse_end");

    // Full vector
    send(8'hFF);
    for (int i = 0; i < 8; i++) begin
      check_grant($sformatf("full_%0d", i), i, (i == 7));
      cycle();
    end
    check_idle("full_end");

    // Empty vector
    send(8'h00);
    check_idle("empty_a");
    cycle();
    check_idle("empty_b");

    // Backpressure on a single-bit vector
    grant_ready = 1'b0;
    send(8'b1000_0000);
    for (int k = 0; k < 3; k++) begin
      check_grant($sformatf("bp_hold_%0d", k), 7, 1'b1);
      cycle();
    end
    grant_ready = 1'b1;
    check_grant("bp_accept", 7, 1'b1);
    cycle();
    check_idle("bp_end");

    // Flush after one handshake
    send(8'b0000_1111);
    check_grant("fl_a", 0, 1'b0);
    cycle();
    check_grant("fl_b", 1, 1'b0);
    grant_ready = 1'b0;
    flush       = 1'b1;
    cycle();
    flush       = 1'b0;
    check_idle("fl_idle");
    cycle();
    check_idle("fl_stay");

    // Asynchronous reset mid-operation
    grant_ready = 1'b1;
    send(8'b0000_1111);
    check_grant("rm_a", 0, 1'b0);
    cycle();
    check_grant("rm_b", 1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rm_async");
    #1;
    rst_n = 1'b1;
    cycle();
    check_idle("rm_after");
    cycle();
    check_idle("rm_stay");

    // Scheduler still works after the mid-operation reset
    send(8'b0100_0010);
    check_grant("post_a", 1, 1'b0);
    cycle();
    check_grant("post_b", 6, 1'b1);
    cycle();
    check_idle("post_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tz_grant_scheduler
`default_nettype wire
